adder_sat_pipe: RTL
===================

# adder_sat_pipe

Parametrised, pipelined, multi-input signed adder with an optional running-accumulate mode and output saturation. It replaces the fixed two-input 32-bit combinational adder in the noise-cancelling datapath. It sums N_IN sample channels (e.g. reference-path taps or anti-noise partial products) through a registered adder tree and delivers one WIDTH-bit result per input beat. The accumulate mode lets the same block integrate error terms across beats.

## Interface
- WIDTH, 32, signed width of each input channel and of the output (≥4)
- N_IN, 4, number of input channels; power of two, 2..16
- L (localparam), log2(N_IN), number of adder-tree stages

- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_data  in  N_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH], two's complement
- in_valid  in  1  beat qualifier
- acc_en  in  1  sampled with in_valid; 1 = add beat sum to the current out_data
- acc_clr  in  1  sampled with in_valid; 1 = ignore the previous out_data for this beat
- out_data  out  WIDTH  signed result, held between beats
- out_valid  out  1  one-cycle strobe per input beat
- out_sat  out  1  result was clipped; meaningful only while out_valid=1, else 0

## Operation
- No backpressure. One beat is accepted every cycle in_valid=1, and every beat produces exactly one out_valid.
- Tree stage s (1..L) registers pairwise sums of stage s-1 at width WIDTH+s, with sign extension before each add. Stage data registers load only when their valid bit is 1 and hold otherwise. Valid bits shift every cycle.
- acc_en and acc_clr travel through the pipeline alongside their beat.
- Final stage, when its valid bit is 1. Let S = tree sum (WIDTH+L bits):
  - acc_clr=1 or acc_en=0: R = S
  - acc_en=1 and acc_clr=0: R = S + sign-extended out_data (WIDTH+L+1 bits)
  - out_data ← clip(R) to [-2^(WIDTH-1), 2^(WIDTH-1)-1]
  - out_sat ← 1 iff R lies outside that range
- acc_clr has priority over acc_en, so clear and load happen in one beat.
- Intermediate tree stages never overflow, because width grows by one bit per stage. Clipping happens only at the final stage.

## Timing
- Latency is L+1 cycles from the in_valid edge to out_valid. For N_IN=4 this is 3 cycles; for N_IN=8 it is 4.
- Throughput is one beat per cycle. Back-to-back accumulate beats chain correctly because the final stage reads its own registered out_data.
- Reset values: out_data=0, out_valid=0, out_sat=0, all pipeline valid bits 0, all tree data registers 0.
- Reset asserted mid-operation discards every in-flight beat. No out_valid may appear after release until new beats have travelled the full latency.
- The accumulator is out_data itself, so reset also clears the accumulation. A beat with acc_en=1 immediately after reset adds to 0.

## Configuration
- ADDER_SAT_PIPE_SAT_EN defined: clipping as described above, and out_sat is live.
- ADDER_SAT_PIPE_SAT_EN undefined:
  - out_data ← R[WIDTH-1:0], i.e. two's-complement wrap.
  - out_sat is tied to 0.
  - Latency and accumulate behaviour are unchanged.

## Test plan
All scenarios use WIDTH=16, N_IN=4 (latency 3) unless stated otherwise.
- Reset, then idle: out_data=0, out_valid=0 and out_sat=0 throughout. Assert rst asynchronously mid-cycle → outputs are 0 with no clk edge required.
- One beat {100,-50,7,3}, acc_en=0 → exactly 3 cycles later out_valid=1, out_data=60, out_sat=0. Afterwards out_data holds 60 and out_valid=0.
- Saturation:
  - {32767×4} → out_data=32767, out_sat=1.
  - {-32768×4} → out_data=-32768, out_sat=1.
  - Without the macro, the same beats give 0xFFFC and 0x0000 respectively, with out_sat=0.
- Accumulate, back-to-back:
  - Beats {1000,0,0,0}×3 with acc_clr=1 on the first beat and acc_en=1 on all → consecutive outputs 1000, 2000, 3000.
  - Next, beat {10000×4} with acc_en=1 → 32767, out_sat=1.
  - Next, beat with acc_clr=1 and acc_en=1 carrying {5,0,0,0} → 5.
- Bubbles and reset:
  - Beats on cycles 0, 2 and 3 → out_valid on cycles 3, 5 and 6 only, with correct data.
  - Assert rst on cycle 1 with 2 beats in flight, release on cycle 2 → no out_valid for those beats.
- N_IN=8, WIDTH=12: beat {2047×8} → latency 4, out_data=2047, out_sat=1. Beat {1,2,…,8} → 36.

Source files
------------

// File: rtl/adder_sat_pipe.sv
// adder_sat_pipe: pipelined N_IN-channel signed adder tree with an optional
// running accumulate and output saturation.
// Optional feature macro: ADDER_SAT_PIPE_SAT_EN. When it is defined, the
// final result is clipped to the WIDTH-bit signed range and out_sat is live.
// When it is undefined, the result wraps in two's complement and out_sat is 0.
// The accumulator is out_data itself, so reset also clears the running sum.
module adder_sat_pipe #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_sat
);

  localparam int L = $clog2(N_IN);
  localparam int RW = WIDTH + L + 1;

  // Bit offset of tree stage s inside the flat tree register. Stage s holds
  // N_IN>>s nodes, each WIDTH+s bits wide, packed one after another.
  function automatic int stageOffset(input int s);
    int off;
    off = 0;
    for (int t = 1; t < s; t++) begin
      off += (N_IN >> t) * (WIDTH + t);
    end
    return off;
  endfunction

  localparam int TREE_BITS = stageOffset(L + 1);
  localparam int LAST_OFS  = stageOffset(L);

  logic [TREE_BITS-1:0] treeQ;
  logic [TREE_BITS-1:0] treeD;
  logic [L-1:0]         validQ;
  logic [L-1:0]         accEnQ;
  logic [L-1:0]         accClrQ;

  logic [WIDTH-1:0]     outDataQ;
  logic [WIDTH-1:0]     outDataD;
  logic                 outValidQ;
  logic                 outSatQ;
  logic                 outSatD;

  // Adder tree. Each node sign-extends its two operands by one bit before the
  // add, so no stage can overflow. A stage only loads when a beat is entering
  // it; otherwise it holds its previous contents.
  for (genvar s = 1; s <= L; s++) begin : gStage
    localparam int SW       = WIDTH + s;
    localparam int OFS      = stageOffset(s);
    localparam int PREV_OFS = stageOffset(s - 1);

    logic stageLoad;

    if (s == 1) begin : gLoad
      assign stageLoad = in_valid;
    end else begin : gLoad
      assign stageLoad = validQ[s-2];
    end

    for (genvar k = 0; k < (N_IN >> s); k++) begin : gNode
      logic [SW-2:0] opA;
      logic [SW-2:0] opB;

      if (s == 1) begin : gSrc
        assign opA = in_data[(2*k)*WIDTH +: WIDTH];
        assign opB = in_data[(2*k+1)*WIDTH +: WIDTH];
      end else begin : gSrc
        assign opA = treeQ[PREV_OFS + (2*k)*(SW-1) +: SW-1];
        assign opB = treeQ[PREV_OFS + (2*k+1)*(SW-1) +: SW-1];
      end

      assign treeD[OFS + k*SW +: SW] =
        stageLoad ? ({opA[SW-2], opA} + {opB[SW-2], opB})
                  : treeQ[OFS + k*SW +: SW];
    end
  end

  // Tree data and the per-stage valid/accumulate flags; flags shift every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      treeQ   <= '0;
      validQ  <= '0;
      accEnQ  <= '0;
      accClrQ <= '0;
    end else begin
      treeQ      <= treeD;
      validQ[0]  <= in_valid;
      accEnQ[0]  <= acc_en;
      accClrQ[0] <= acc_clr;
      for (int i = 1; i < L; i++) begin
        validQ[i]  <= validQ[i-1];
        accEnQ[i]  <= accEnQ[i-1];
        accClrQ[i] <= accClrQ[i-1];
      end
    end
  end

  logic [WIDTH+L-1:0] treeSum;
  logic [RW-1:0]      sumExt;
  logic [RW-1:0]      accExt;
  logic [RW-1:0]      result;
  logic               accumulate;

  assign treeSum = treeQ[LAST_OFS +: WIDTH+L];

  // Final-stage sum: the tree total, optionally plus the registered output.
  // Clear wins over enable so a single beat can restart the accumulation.
  always_comb begin
    sumExt     = {treeSum[WIDTH+L-1], treeSum};
    accExt     = {{(L+1){outDataQ[WIDTH-1]}}, outDataQ};
    accumulate = accEnQ[L-1] && !accClrQ[L-1];
    result     = accumulate ? (sumExt + accExt) : sumExt;
  end

`ifdef ADDER_SAT_PIPE_SAT_EN
  logic overflow;

  // The result fits in WIDTH bits only if every bit from WIDTH-1 upward
  // matches; otherwise clip toward the sign of the full-precision result.
  always_comb begin
    overflow = !((&result[RW-1:WIDTH-1]) || !(|result[RW-1:WIDTH-1]));
    outSatD  = overflow;
    if (overflow) begin
      outDataD = result[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      outDataD = result[WIDTH-1:0];
    end
  end
`else
  logic unusedHighBits;

  // Without saturation the result simply wraps to its low WIDTH bits.
  always_comb begin
    outDataD = result[WIDTH-1:0];
    outSatD  = 1'b0;
  end

  assign unusedHighBits = ^result[RW-1:WIDTH];
`endif

  // Output register: data holds between beats, valid and sat are strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outDataQ  <= '0;
      outValidQ <= 1'b0;
      outSatQ   <= 1'b0;
    end else begin
      outValidQ <= validQ[L-1];
      outSatQ   <= validQ[L-1] & outSatD;
      if (validQ[L-1]) begin
        outDataQ <= outDataD;
      end
    end
  end

  assign out_data  = outDataQ;
  assign out_valid = outValidQ;
  assign out_sat   = outSatQ;

endmodule
